// File: rtl/present_pkg.sv
//------------------------------------------------------------------------------
// present_pkg : shared PRESENT-80 constants, S-box tables, bit permutations
//               and the decryptor FSM state encoding.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package present_pkg;

    localparam int DATA_W = 64;
    localparam int KEY_W  = 80;
    localparam int ROUNDS = 31;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    localparam logic [3:0] INV_SBOX [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_KEYEXP = 2'd1,
        ST_DEC    = 2'd2,
        ST_FIN    = 2'd3
    } dec_state_e;

    // Bit j moves to position 16*j mod 63; bit 63 stays in place.
    function automatic logic [DATA_W-1:0] p_layer(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] y;
        logic [5:0]        dst;
        y = '0;
        for (int j = 0; j < 63; j++) begin
            dst    = 6'((16 * j) % 63);
            y[dst] = x[6'(j)];
        end
        y[63] = x[63];
        return y;
    endfunction

    function automatic logic [DATA_W-1:0] inv_p_layer(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] y;
        logic [5:0]        src;
        y = '0;
        for (int j = 0; j < 63; j++) begin
            src      = 6'((16 * j) % 63);
            y[6'(j)] = x[src];
        end
        y[63] = x[63];
        return y;
    endfunction

endpackage

`default_nettype wire

// File: rtl/present_decrypt_core_if.sv
//------------------------------------------------------------------------------
// present_decrypt_core_if : load/ready/valid handshake bundle of the decryptor.
// Revision                : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface present_decrypt_core_if;
    import present_pkg::*;

    logic [DATA_W-1:0] idat;
    logic [KEY_W-1:0]  key;
    logic              load;
    logic              ready;
    logic [DATA_W-1:0] odat;
    logic              odat_valid;

    modport master (
        output idat,
        output key,
        output load,
        input  ready,
        input  odat,
        input  odat_valid
    );

    modport slave (
        input  idat,
        input  key,
        input  load,
        output ready,
        output odat,
        output odat_valid
    );

endinterface

`default_nettype wire

// File: rtl/present_decrypt_sbox.sv
//------------------------------------------------------------------------------
// present_decrypt_sbox : 4-bit PRESENT inverse S-box (pure combinational).
// Revision             : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module present_decrypt_sbox
    import present_pkg::*;
(
    input  wire logic [3:0] x_i,
    output logic      [3:0] y_o
);

    assign y_o = INV_SBOX[x_i];

endmodule

`default_nettype wire

// File: rtl/present_decrypt_core.sv
//------------------------------------------------------------------------------
// present_decrypt_core : iterative PRESENT-80 decryptor; expands K1 to K32
//                        on-chip, then runs the inverse rounds back to K1.
// Revision             : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module present_decrypt_core #(
    parameter int ROUNDS = 31
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    present_decrypt_core_if.slave        bus
);
    import present_pkg::*;

    localparam logic [4:0] c_LAST_ROUND  = 5'(ROUNDS);
    localparam logic [4:0] c_FIRST_ROUND = 5'd1;

    dec_state_e         state_q, state_d;
    logic [4:0]         round_q, round_d;
    logic [DATA_W-1:0]  dreg_q,  dreg_d;
    logic [KEY_W-1:0]   kreg_q,  kreg_d;
    logic [DATA_W-1:0]  odat_q,  odat_d;
    logic               valid_q, valid_d;

    logic [KEY_W-1:0]   w_key_rotl;
    logic [KEY_W-1:0]   w_key_fwd;
    logic [3:0]         w_key_nib_inv;
    logic [KEY_W-1:0]   w_key_unmix;
    logic [KEY_W-1:0]   w_key_inv;
    logic [DATA_W-1:0]  w_round_in;
    logic [DATA_W-1:0]  w_perm;
    logic [DATA_W-1:0]  w_data_inv;

    // Forward schedule, identical to the encryptor: K(i) -> K(i+1).
    assign w_key_rotl = {kreg_q[18:0], kreg_q[79:19]};
    assign w_key_fwd  = {SBOX[w_key_rotl[79:76]],
                         w_key_rotl[75:20],
                         w_key_rotl[19:15] ^ round_q,
                         w_key_rotl[14:0]};

    // Inverse schedule: K(i+1) -> K(i), undoing the forward steps in reverse.
    present_decrypt_sbox u_key_sbox (
        .x_i (kreg_q[79:76]),
        .y_o (w_key_nib_inv)
    );

    assign w_key_unmix = {w_key_nib_inv,
                          kreg_q[75:20],
                          kreg_q[19:15] ^ round_q,
                          kreg_q[14:0]};
    assign w_key_inv   = {w_key_unmix[60:0], w_key_unmix[79:61]};

    assign w_round_in = dreg_q ^ kreg_q[79:16];
    assign w_perm     = inv_p_layer(w_round_in);

    genvar g;
    generate
        for (g = 0; g < DATA_W / 4; g++) begin : g_data_sbox
            present_decrypt_sbox u_sbox (
                .x_i (w_perm[4*g +: 4]),
                .y_o (w_data_inv[4*g +: 4])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            dreg_q  <= '0;
            kreg_q  <= '0;
            odat_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            dreg_q  <= dreg_d;
            kreg_q  <= kreg_d;
            odat_q  <= odat_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        dreg_d  = dreg_q;
        kreg_d  = kreg_q;
        odat_d  = odat_q;
        valid_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.load) begin
                    dreg_d  = bus.idat;
                    kreg_d  = bus.key;
                    round_d = c_FIRST_ROUND;
                    state_d = ST_KEYEXP;
                end
            end

            ST_KEYEXP: begin
                kreg_d = w_key_fwd;
                if (round_q == c_LAST_ROUND) begin
                    state_d = ST_DEC;
                end else begin
                    round_d = round_q + 5'd1;
                end
            end

            // The round value XORed into the key is the pre-decrement one.
            ST_DEC: begin
                dreg_d  = w_data_inv;
                kreg_d  = w_key_inv;
                round_d = round_q - 5'd1;
                if (round_q == c_FIRST_ROUND) begin
                    state_d = ST_FIN;
                end
            end

            ST_FIN: begin
                odat_d  = w_round_in;
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.ready      = (state_q == ST_IDLE);
    assign bus.odat       = odat_q;
    assign bus.odat_valid = valid_q;

endmodule

`default_nettype wire
